// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared types and widths for the SRAM arbiter
//
// Purpose: holds the access FSM state type, the requester count and the
// SRAM address/data widths used by sram_arbiter and sram_arb_pick.
// Ports: none (package).

package sram_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 20;
  localparam int DATA_W  = 16;
  localparam int BE_W    = DATA_W / 8;
  localparam int CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } arb_state_e;

  // Index of the set bit in a two-requester one-hot grant.
  function automatic logic grant_idx(input logic [NUM_REQ-1:0] grant);
    return grant[1];
  endfunction

endpackage

// File: rtl/sram_arb_pick.sv
// rtl/sram_arb_pick.sv - winner select for the two-requester SRAM arbiter
//
// Purpose: turns the request vector into a one-hot grant. A lone request
// always wins; on a tie the requester that was NOT granted last wins.
// Feeding last_grant=1 constantly yields fixed priority to requester 0.
// Ports:
//   req        in  [NUM_REQ-1:0]  request vector, bit i = requester i
//   last_grant in  1              index of the requester granted last
//   grant      out [NUM_REQ-1:0]  one-hot grant, zero when no request

module sram_arb_pick
  import sram_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic               last_grant,
  output logic [NUM_REQ-1:0] grant
);

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-requester arbiter driving an async SRAM
//
// Purpose: grants one of two requesters, then runs a SETUP / STROBE x
// WAIT_CYCLES / HOLD access on an asynchronous SRAM and pulses ack for the
// winner in HOLD. Read data is captured from sram_dq on entry to HOLD.
// Optional feature: define SRAM_ARB_RR_EN for round-robin tie breaking;
// otherwise requester 0 wins every tie and no pointer register is built.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   req[1:0]          per-requester request
//   we[1:0]           per-requester direction, 1 = write
//   addr[39:0]        requester i word address at [20i+19:20i]
//   wdata[31:0]       requester i write data at [16i+15:16i]
//   be[3:0]           requester i byte enables at [2i+1:2i], low bit = low byte
//   ack[1:0]          one-cycle completion pulse per requester
//   rdata[15:0]       read data, meaningful in the ack cycle
//   busy              FSM not in IDLE
//   sram_addr, sram_dq, sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n

module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  input  logic [NUM_REQ*BE_W-1:0]   be,
  output logic [NUM_REQ-1:0]        ack,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic [ADDR_W-1:0]         sram_addr,
  inout  wire  [DATA_W-1:0]         sram_dq,
  output logic                      sram_ce_n,
  output logic                      sram_we_n,
  output logic                      sram_oe_n,
  output logic                      sram_lb_n,
  output logic                      sram_ub_n
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

  arb_state_e          state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;
  logic [NUM_REQ-1:0]  grant_q;
  logic [DATA_W-1:0]   rdata_q;

  logic [NUM_REQ-1:0]  grant_win;
  logic                win_idx;
  logic                last_grant;
  logic                capture;
  logic                load_rdata;
  logic                dq_oe;

  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

`ifdef SRAM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
    end else if (capture) begin
      last_grant_q <= win_idx;
    end
  end

  assign last_grant = last_grant_q;
`else
  // Pretending requester 1 was always granted last makes every tie go to 0.
  assign last_grant = 1'b1;
`endif

  sram_arb_pick u_pick (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant_win)
  );

  assign win_idx   = grant_idx(grant_win);
  assign sel_we    = win_idx ? we[1] : we[0];
  assign sel_addr  = win_idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
  assign sel_wdata = win_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  assign sel_be    = win_idx ? be[2*BE_W-1:BE_W] : be[BE_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Transfer attributes are frozen at grant so req/we/addr changes during a
  // transfer cannot disturb it. addr_q doubles as sram_addr, which therefore
  // keeps its last value through IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      grant_q <= '0;
    end else if (capture) begin
      we_q    <= sel_we;
      addr_q  <= sel_addr;
      wdata_q <= sel_wdata;
      be_q    <= sel_be;
      grant_q <= grant_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (load_rdata) begin
      rdata_q <= sram_dq;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    capture    = 1'b0;
    load_rdata = 1'b0;
    busy       = 1'b1;
    ack        = '0;
    dq_oe      = 1'b0;
    sram_ce_n  = 1'b1;
    sram_we_n  = 1'b1;
    sram_oe_n  = 1'b1;
    sram_lb_n  = 1'b1;
    sram_ub_n  = 1'b1;

    if (state_q != IDLE) begin
      sram_ce_n = 1'b0;
      sram_oe_n = we_q;
      sram_lb_n = ~be_q[0];
      sram_ub_n = ~be_q[1];
      dq_oe     = we_q;
    end

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        if (|req) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        sram_we_n = ~we_q;
        if (cnt_q == CNT_LAST) begin
          state_d    = HOLD;
          load_rdata = ~we_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        ack     = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign sram_addr = addr_q;
  assign rdata     = rdata_q;
  assign sram_dq   = dq_oe ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, giving the number of access-strobe cycles per transfer (legal range 1..15).
REQ-002 The block SHALL have port clk  input  1  system clock; all logic runs on its rising edge.
REQ-003 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port req  input  2  per-requester access request; bit i is requester i.
REQ-005 The block SHALL have port we  input  2  per-requester direction; 1 = write, 0 = read.
REQ-006 The block SHALL have port addr  input  40  per-requester word address; requester i uses bits [20i+19:20i].
REQ-007 The block SHALL have port wdata  input  32  per-requester write data; requester i uses bits [16i+15:16i].
REQ-008 The block SHALL have port be  input  4  per-requester byte enables, active-high; requester i uses bits [2i+1:2i], where the low bit is the low byte.
REQ-009 The block SHALL have port ack  output  2  one-cycle completion pulse per requester.
REQ-010 The block SHALL have port rdata  output  16  read data, valid only in the cycle in which the matching ack is high.
REQ-011 The block SHALL have port busy  output  1  high whenever the FSM is not in IDLE.
REQ-012 The block SHALL have ports sram_addr (output, 20), sram_dq (inout, 16), and sram_ce_n, sram_we_n, sram_oe_n, sram_lb_n, sram_ub_n (each output, 1, active-low).

Function
REQ-013 The FSM SHALL have states IDLE, SETUP, STROBE and HOLD.
REQ-014 In IDLE, when any req bit is high, the block SHALL select one winner and latch its we, addr, wdata and be, and SHALL move to SETUP on the next edge.
REQ-015 In SETUP, the block SHALL drive sram_addr, drive sram_ce_n=0 and drive lb_n/ub_n=~be.
  - For a read, it SHALL also drive oe_n=0.
  - For a write, it SHALL drive sram_dq=wdata with oe_n=1.
  - sram_we_n SHALL remain 1.
REQ-016 STROBE SHALL last exactly WAIT_CYCLES cycles, counted by an internal counter, and SHALL keep all SETUP signals; for a write, sram_we_n SHALL be 0 throughout STROBE.
REQ-017 HOLD SHALL last one cycle. In HOLD:
  - sram_we_n SHALL be 1.
  - addr and dq SHALL still be held.
  - For a read, the block SHALL register sram_dq into rdata on entry to HOLD.
  - ack[winner] SHALL be 1.
  - The next state SHALL be IDLE.
REQ-018 Latency from req sampled high in IDLE to ack SHALL be exactly WAIT_CYCLES+2 cycles; each transfer SHALL occupy WAIT_CYCLES+3 cycles including the return to IDLE.
REQ-019 The sram_dq output enable SHALL be high only in SETUP, STROBE and HOLD of a write; in all other cycles sram_dq SHALL be high-Z.
REQ-020 In IDLE, the SRAM controls SHALL be sram_ce_n=1, sram_we_n=1, sram_oe_n=1, lb_n=1, ub_n=1, and sram_addr SHALL hold its last value.
REQ-021 Request signals SHALL be sampled only in IDLE; req changes during a transfer SHALL have no effect on that transfer.
REQ-022 A requester SHALL deassert req in the cycle after its ack; if req is still high in IDLE, it SHALL be treated as a new request.
REQ-023 A request with be=2'b00 SHALL still run the full cycle and be acked, with lb_n=ub_n=1 throughout.

Reset
REQ-024 Assertion of rst_n at any time, including mid-transfer, SHALL immediately apply the following, and the pending transfer SHALL be dropped with no ack:
  - state returns to IDLE, busy=0;
  - ack=0, rdata=0, sram_addr=0;
  - all SRAM strobes are 1 and sram_dq is high-Z;
  - the counter is cleared;
  - the last-grant pointer is set to 1.

Configuration
REQ-025 With SRAM_ARB_RR_EN defined, arbitration SHALL be round-robin: when both req bits are high, the requester not granted last SHALL win, and the pointer SHALL update at each grant.
REQ-026 Without SRAM_ARB_RR_EN, arbitration SHALL be fixed priority with requester 0 always winning a tie, and no pointer register SHALL exist.

Structure
REQ-027 A shared package SHALL hold the FSM state enum, the requester count (2), and the width constants ADDR_W=20 and DATA_W=16.
REQ-028 The winner-select logic SHALL be a sub-module sram_arb_pick, with inputs req and last_grant, and output a one-hot grant.

Verification
REQ-029 The bench SHALL cover: WAIT_CYCLES=2, requester 0 writes addr 0x00012 with data 0x1234 and be=11. Required response: we_n low for exactly 2 cycles, ack[0] 4 cycles after req, dq high-Z afterwards.
REQ-030 The bench SHALL cover: requester 1 reads addr 0x00012 after that write, with the SRAM model returning 0x1234. Required response: rdata=0x1234 exactly in the ack[1] cycle.
REQ-031 The bench SHALL cover: both requesters request continuously with SRAM_ARB_RR_EN defined. Required response: grants alternate 0,1,0,1; without the macro, requester 0 is granted every time.
REQ-032 The bench SHALL cover: a write with be=01. Required response: lb_n=0 and ub_n=1 during SETUP through HOLD.
REQ-033 The bench SHALL cover: rst_n pulsed low during STROBE of a write. Required response: we_n and ce_n=1 and dq high-Z within the same cycle, no ack, busy=0.
REQ-034 The bench SHALL cover: requester 0 holds req high one cycle past ack with requester 1 idle. Required response: a second transfer starts, and busy stays high apart from a single IDLE cycle.
